// File: rtl/blk_mem_pkg.sv
// Shared sizing helpers and request record for the dual-port block RAM.
// Word index = byte address with the byte-offset bits dropped.
package blk_mem_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 12;

    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int num_words(input int data_width, input int addr_width);
        return 1 << (addr_width - byte_shift(data_width));
    endfunction

    // Request record at the default geometry (32-bit words, 12-bit byte address)
    typedef struct packed {
        logic                        en;
        logic [DEF_DATA_WIDTH/8-1:0] we;
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic [DEF_DATA_WIDTH-1:0]   din;
    } mem_req_t;

endpackage

// File: rtl/blk_mem_rd_pipe.sv
// Read-data delay line behind the array read register: DEPTH data/valid stages,
// each stage loads only on its own incoming valid so bubbles keep the last word.
module blk_mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 0
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  w_vld [DEPTH+1];
    logic [DATA_WIDTH-1:0] w_dat [DEPTH+1];

    assign w_vld[0] = i_vld;
    assign w_dat[0] = i_data;

    for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
        logic                  r_vld;
        logic [DATA_WIDTH-1:0] r_dat;

        always_ff @(posedge i_clk) begin
            if (i_srst) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_vld[s-1];
                if (w_vld[s-1]) r_dat <= w_dat[s-1];
            end
        end

        assign w_vld[s] = r_vld;
        assign w_dat[s] = r_dat;
    end

    assign o_vld  = w_vld[DEPTH];
    assign o_data = w_dat[DEPTH];

endmodule

// File: rtl/blk_mem_dp_pipe.sv
// True dual-port byte-strobed RAM with fully pipelined reads on both ports.
// Same-word writes: port A bytes win; read vs write on the same word is read-first.
module blk_mem_dp_pipe
    import blk_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_srst,
    input  logic                    i_en_a,
    input  logic [DATA_WIDTH/8-1:0] i_we_a,
    input  logic [ADDR_WIDTH-1:0]   i_addr_a,
    input  logic [DATA_WIDTH-1:0]   i_din_a,
    output logic [DATA_WIDTH-1:0]   o_dout_a,
    output logic                    o_valid_a,
    input  logic                    i_en_b,
    input  logic [DATA_WIDTH/8-1:0] i_we_b,
    input  logic [ADDR_WIDTH-1:0]   i_addr_b,
    input  logic [DATA_WIDTH-1:0]   i_din_b,
    output logic [DATA_WIDTH-1:0]   o_dout_b,
    output logic                    o_valid_b
);

    localparam int NB         = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);
    localparam int NUM_WORDS  = num_words(DATA_WIDTH, ADDR_WIDTH);
    localparam int IW         = ADDR_WIDTH - BYTE_SHIFT;

    if (DATA_WIDTH % 8 != 0 || READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_cfg
        $error("blk_mem_dp_pipe: DATA_WIDTH must be a multiple of 8 and READ_LATENCY within 1..4");
    end

    typedef struct packed {
        logic                  en;
        logic [NB-1:0]         we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } port_req_t;

    port_req_t             w_req      [2];
    logic [IW-1:0]         w_idx      [2];
    logic                  w_rd       [2];
    logic                  w_pipe_vld [2];
    logic [DATA_WIDTH-1:0] w_pipe_dat [2];
    logic                  r_rd_vld   [2];
    logic [DATA_WIDTH-1:0] r_rd_dat   [2];
    logic [DATA_WIDTH-1:0] r_mem      [NUM_WORDS];

    assign w_req[0] = '{en: i_en_a, we: i_we_a, addr: i_addr_a, din: i_din_a};
    assign w_req[1] = '{en: i_en_b, we: i_we_b, addr: i_addr_b, din: i_din_b};

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_idx[p] = w_req[p].addr[ADDR_WIDTH-1:BYTE_SHIFT];
        assign w_rd[p]  = w_req[p].en && (w_req[p].we == '0);

        if (BYTE_SHIFT > 0) begin : g_lo
            logic w_unused_lo;
            assign w_unused_lo = ^w_req[p].addr[BYTE_SHIFT-1:0];
        end

        blk_mem_rd_pipe #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (READ_LATENCY - 1)
        ) u_rd_pipe (
            .i_clk (i_clk),
            .i_srst(i_srst),
            .i_vld (r_rd_vld[p]),
            .i_data(r_rd_dat[p]),
            .o_vld (w_pipe_vld[p]),
            .o_data(w_pipe_dat[p])
        );
    end

    // Port B is visited first so that A's nonblocking byte update lands last on a shared byte.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int p = 0; p < 2; p++) begin
                r_rd_vld[p] <= 1'b0;
                r_rd_dat[p] <= '0;
            end
        end else begin
            for (int p = 1; p >= 0; p--) begin
                r_rd_vld[p] <= w_rd[p];
                if (w_rd[p]) r_rd_dat[p] <= r_mem[w_idx[p]];
                for (int i = 0; i < NB; i++) begin
                    if (w_req[p].en && w_req[p].we[i])
                        r_mem[w_idx[p]][i*8 +: 8] <= w_req[p].din[i*8 +: 8];
                end
            end
        end
    end

    assign o_valid_a = w_pipe_vld[0];
    assign o_dout_a  = w_pipe_dat[0];
    assign o_valid_b = w_pipe_vld[1];
    assign o_dout_b  = w_pipe_dat[1];

endmodule

// File: tb/tb_blk_mem_dp_pipe.sv
// Drives four instances (READ_LATENCY 1..4) with identical stimulus and checks
// every output each cycle against a word-array/read-history reference.
module tb_blk_mem_dp_pipe;
    import blk_mem_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 12;
    localparam int NL   = 4;
    localparam int NW   = 1024;
    localparam int MAXE = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     srst;
    mem_req_t ra, rb;

    logic [DW-1:0] dout_a  [NL];
    logic [DW-1:0] dout_b  [NL];
    logic          valid_a [NL];
    logic          valid_b [NL];

    for (genvar L = 1; L <= NL; L++) begin : g_dut
        blk_mem_dp_pipe #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .READ_LATENCY(L)
        ) u_dut (
            .i_clk    (clk),
            .i_srst   (srst),
            .i_en_a   (ra.en),
            .i_we_a   (ra.we),
            .i_addr_a (ra.addr),
            .i_din_a  (ra.din),
            .o_dout_a (dout_a[L-1]),
            .o_valid_a(valid_a[L-1]),
            .i_en_b   (rb.en),
            .i_we_b   (rb.we),
            .i_addr_b (rb.addr),
            .i_din_b  (rb.din),
            .o_dout_b (dout_b[L-1]),
            .o_valid_b(valid_b[L-1])
        );
    end

    // Reference: word array plus, per port, what each accepted read returned and when.
    logic [DW-1:0] mem [NW];
    bit            rd_hit [2][MAXE];
    logic [DW-1:0] rd_dat [2][MAXE];
    int            edge_n   = 0;
    int            last_rst = 0;
    int            checks   = 0;
    int            errors   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t mk(input logic en, input logic [3:0] we,
                                    input logic [11:0] addr, input logic [31:0] din);
        mem_req_t r;
        r.en = en; r.we = we; r.addr = addr; r.din = din;
        return r;
    endfunction

    // A read accepted at edge k is visible after edge k+L-1; a reset edge after k kills it
    // and zeroes dout; dout otherwise shows the newest delivered read.
    task automatic model_check();
        int            k;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        for (int L = 1; L <= NL; L++) begin
            for (int p = 0; p < 2; p++) begin
                k     = edge_n - L + 1;
                exp_v = 1'b0;
                exp_d = '0;
                if (k > last_rst && k >= 1 && rd_hit[p][k]) exp_v = 1'b1;
                for (int j = k; j > last_rst && j >= 1; j--) begin
                    if (rd_hit[p][j]) begin
                        exp_d = rd_dat[p][j];
                        break;
                    end
                end
                if (p == 0) begin
                    chk($sformatf("valid_a L%0d e%0d", L, edge_n), {31'd0, valid_a[L-1]}, {31'd0, exp_v});
                    chk($sformatf("dout_a L%0d e%0d", L, edge_n), dout_a[L-1], exp_d);
                end else begin
                    chk($sformatf("valid_b L%0d e%0d", L, edge_n), {31'd0, valid_b[L-1]}, {31'd0, exp_v});
                    chk($sformatf("dout_b L%0d e%0d", L, edge_n), dout_b[L-1], exp_d);
                end
            end
        end
    endtask

    task automatic tick(input mem_req_t a, input mem_req_t b, input logic rst);
        int wa, wb;
        ra   = a;
        rb   = b;
        srst = rst;
        @(posedge clk);
        edge_n++;
        wa = int'(a.addr[AW-1:2]);
        wb = int'(b.addr[AW-1:2]);
        if (rst) begin
            last_rst = edge_n;
        end else begin
            rd_hit[0][edge_n] = a.en && (a.we == 4'h0);
            rd_dat[0][edge_n] = mem[wa];
            rd_hit[1][edge_n] = b.en && (b.we == 4'h0);
            rd_dat[1][edge_n] = mem[wb];
            for (int i = 0; i < 4; i++) begin
                if (b.en && b.we[i] && !(a.en && a.we[i] && wa == wb))
                    mem[wb][i*8 +: 8] = b.din[i*8 +: 8];
                if (a.en && a.we[i])
                    mem[wa][i*8 +: 8] = a.din[i*8 +: 8];
            end
        end
        #1;
        model_check();
    endtask

    mem_req_t idle;

    initial begin
        idle = '0;
        ra   = '0;
        rb   = '0;
        srst = 1'b1;
        for (int i = 0; i < NW; i++) mem[i] = '0;

        tick(idle, idle, 1'b1);
        tick(idle, idle, 1'b1);
        for (int L = 0; L < NL; L++) begin
            chk($sformatf("reset valid_a L%0d", L + 1), {31'd0, valid_a[L]}, 32'd0);
            chk($sformatf("reset dout_b L%0d", L + 1), dout_b[L], 32'd0);
        end

        for (int i = 0; i < 32; i++)
            tick(mk(1'b1, 4'hF, 12'(i * 4), $urandom), mk(1'b1, 4'hF, 12'((i + 32) * 4), $urandom), 1'b0);

        // single read, latency-3 instance
        tick(mk(1'b1, 4'hF, 12'h010, 32'hDEADBEEF), idle, 1'b0);
        tick(idle, mk(1'b1, 4'h0, 12'h010, 32'h0), 1'b0);
        tick(idle, idle, 1'b0);
        chk("lat3 early valid", {31'd0, valid_b[2]}, 32'd0);
        tick(idle, idle, 1'b0);
        chk("lat3 valid", {31'd0, valid_b[2]}, 32'd1);
        chk("lat3 data", dout_b[2], 32'hDEADBEEF);
        tick(idle, idle, 1'b0);
        chk("lat3 single pulse", {31'd0, valid_b[2]}, 32'd0);

        // back-to-back reads of an index-valued prefill
        for (int i = 0; i < 8; i++) tick(mk(1'b1, 4'hF, 12'(i * 4), 32'(i)), idle, 1'b0);
        for (int i = 0; i < 8; i++) tick(mk(1'b1, 4'h0, 12'(i * 4), 32'h0), idle, 1'b0);
        repeat (5) tick(idle, idle, 1'b0);

        // byte strobes
        tick(mk(1'b1, 4'hF, 12'h040, 32'h11223344), idle, 1'b0);
        tick(mk(1'b1, 4'b0101, 12'h040, 32'hAABBCCDD), idle, 1'b0);
        tick(mk(1'b1, 4'h0, 12'h040, 32'h0), idle, 1'b0);
        repeat (4) tick(idle, idle, 1'b0);
        for (int L = 0; L < NL; L++) chk($sformatf("strobe L%0d", L + 1), dout_a[L], 32'h11BB33DD);

        // same-word write collision
        tick(mk(1'b1, 4'b0011, 12'h020, 32'hAAAAAAAA), mk(1'b1, 4'hF, 12'h020, 32'hBBBBBBBB), 1'b0);
        tick(mk(1'b1, 4'h0, 12'h020, 32'h0), idle, 1'b0);
        repeat (4) tick(idle, idle, 1'b0);
        for (int L = 0; L < NL; L++) chk($sformatf("collision L%0d", L + 1), dout_a[L], 32'hBBBBAAAA);

        // read during write on the other port
        tick(mk(1'b1, 4'hF, 12'h030, 32'h5), idle, 1'b0);
        tick(mk(1'b1, 4'hF, 12'h030, 32'h9), mk(1'b1, 4'h0, 12'h030, 32'h0), 1'b0);
        chk("rdw old word", dout_b[0], 32'h5);
        tick(idle, mk(1'b1, 4'h0, 12'h030, 32'h0), 1'b0);
        chk("rdw new word", dout_b[0], 32'h9);

        // reset with reads in flight
        repeat (2) tick(idle, idle, 1'b0);
        tick(mk(1'b1, 4'h0, 12'h000, 32'h0), idle, 1'b0);
        tick(mk(1'b1, 4'h0, 12'h004, 32'h0), idle, 1'b0);
        tick(mk(1'b1, 4'h0, 12'h008, 32'h0), idle, 1'b0);
        tick(mk(1'b1, 4'hF, 12'h004, 32'hFFFFFFFF), idle, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(idle, idle, 1'b0);
            chk($sformatf("flush valid c%0d", c), {31'd0, valid_a[3]}, 32'd0);
            chk($sformatf("flush dout c%0d", c), dout_a[3], 32'd0);
        end
        tick(mk(1'b1, 4'h0, 12'h004, 32'h0), idle, 1'b0);
        repeat (3) tick(idle, idle, 1'b0);
        chk("post-reset valid", {31'd0, valid_a[3]}, 32'd1);
        chk("array kept", dout_a[3], 32'h1);

        // random traffic over the prefilled region
        repeat (300) begin
            mem_req_t a, b;
            a = mk(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                   12'($urandom_range(0, 255)), $urandom);
            b = mk(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                   12'($urandom_range(0, 255)), $urandom);
            tick(a, b, 1'($urandom_range(0, 39) == 0));
        end
        repeat (5) tick(idle, idle, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
